// File: rtl/ctrl_sequencer.sv
// Registered opcode sequencer between instruction fetch and the datapath.
// Takes one opcode per valid/ready handshake and holds the ALU/memory
// control word until the operation completes. MAC waits for a number of
// datapath-advance cycles. LD/ST wait for a memory ack, with a timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | ready for an opcode, control word at NOP
// S_EXEC     | single-cycle ALU op, waiting for the datapath to advance
// S_MAC_HOLD | MAC in flight, cnt_q = advance cycles still needed - 1
// S_MEM_WAIT | LD/ST request out, waiting for mem_ack or timeout
module ctrl_sequencer #(
    parameter int ALUCTL_W    = 3,
    parameter int MAC_LAT     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [3:0]           opcode_i,
    output logic                 ctrl_valid_o,
    input  logic                 ctrl_ready_i,
    output logic [ALUCTL_W-1:0]  alu_ctrl1_o,
    output logic [ALUCTL_W-1:0]  alu_ctrl2_o,
    output logic                 alu_src_o,
    output logic                 reg_dst_o,
    output logic                 mem_to_reg_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    input  logic                 mem_ack_i,
    output logic                 reg_write_o,
    output logic                 illegal_op_o,
    output logic                 mem_timeout_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(MAC_LAT - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_MUL  = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_NOP  = {ALUCTL_W{1'b1}};

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_SLT = 4'h3;
    localparam logic [3:0] OP_MAC = 4'h4;
    localparam logic [3:0] OP_LD  = 4'hE;
    localparam logic [3:0] OP_ST  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MAC_HOLD,
        S_MEM_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [ALUCTL_W-1:0]  alu1_q, alu1_d;
    logic [ALUCTL_W-1:0]  alu2_q, alu2_d;
    logic                 ctrl_valid_q, ctrl_valid_d;
    logic                 mem_to_reg_q, mem_to_reg_d;
    logic                 mem_write_q, mem_write_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 illegal_q, illegal_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 done;

    // State and control-word registers; reset drops any operation in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            alu1_q       <= ALU_NOP;
            alu2_q       <= ALU_NOP;
            ctrl_valid_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            illegal_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu1_q       <= alu1_d;
            alu2_q       <= alu2_d;
            ctrl_valid_q <= ctrl_valid_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            illegal_q    <= illegal_d;
            err_q        <= err_d;
        end
    end

    // Next state, control word load on accept, completion pulses.
    always_comb begin
        state_d       = state_q;
        alu1_d        = alu1_q;
        alu2_d        = alu2_q;
        ctrl_valid_d  = ctrl_valid_q;
        mem_to_reg_d  = mem_to_reg_q;
        mem_write_d   = mem_write_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        illegal_d     = 1'b0;
        err_d         = err_q;
        reg_write_o   = 1'b0;
        mem_timeout_o = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    case (opcode_i)
                        OP_ADD, OP_MUL, OP_SLT: begin
                            state_d      = S_EXEC;
                            ctrl_valid_d = 1'b1;
                            alu1_d       = (opcode_i == OP_ADD) ? ALU_ADD :
                                           (opcode_i == OP_MUL) ? ALU_MUL : ALU_SLT;
                        end
                        OP_MAC: begin
                            state_d      = S_MAC_HOLD;
                            ctrl_valid_d = 1'b1;
                            alu1_d       = ALU_MUL;
                            alu2_d       = ALU_ADD;
                            cnt_d        = CNT_INIT;
                        end
                        OP_LD, OP_ST: begin
                            state_d      = S_MEM_WAIT;
                            ctrl_valid_d = 1'b1;
                            mem_to_reg_d = (opcode_i == OP_LD);
                            mem_write_d  = (opcode_i == OP_ST);
                            tmo_d        = '0;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            if (err_q != {ERR_CNT_W{1'b1}}) begin
                                err_d = err_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if (ctrl_ready_i) begin
                    reg_write_o = 1'b1;
                    done        = 1'b1;
                end
            end
            S_MAC_HOLD: begin
                if (ctrl_ready_i) begin
                    if (cnt_q == '0) begin
                        reg_write_o = 1'b1;
                        done        = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_MEM_WAIT: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem_ack_i) begin
                    reg_write_o = mem_to_reg_q;
                    done        = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    mem_timeout_o = 1'b1;
                    done          = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            state_d      = S_IDLE;
            ctrl_valid_d = 1'b0;
            alu1_d       = ALU_NOP;
            alu2_d       = ALU_NOP;
            mem_to_reg_d = 1'b0;
            mem_write_d  = 1'b0;
        end
    end

    assign instr_ready_o = (state_q == S_IDLE);
    assign ctrl_valid_o  = ctrl_valid_q;
    assign alu_ctrl1_o   = alu1_q;
    assign alu_ctrl2_o   = alu2_q;
    assign alu_src_o     = 1'b0;
    assign reg_dst_o     = 1'b0;
    assign mem_to_reg_o  = mem_to_reg_q;
    assign mem_req_o     = (state_q == S_MEM_WAIT);
    assign mem_write_o   = mem_write_q;
    assign illegal_op_o  = illegal_q;
    assign err_count_o   = err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a
// transaction-level model.
module tb_ctrl_sequencer;

    localparam int ALUCTL_W    = 3;
    localparam int MAC_LAT     = 2;
    localparam int MEM_TIMEOUT = 16;
    localparam int ERR_CNT_W   = 2;
    localparam int ERR_MAX     = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 instr_valid = 1'b0;
    logic                 instr_ready;
    logic [3:0]           opcode = 4'h0;
    logic                 ctrl_valid;
    logic                 ctrl_ready = 1'b0;
    logic [ALUCTL_W-1:0]  alu_ctrl1, alu_ctrl2;
    logic                 alu_src, reg_dst, mem_to_reg, mem_req, mem_write;
    logic                 mem_ack = 1'b0;
    logic                 reg_write, illegal_op, mem_timeout;
    logic [ERR_CNT_W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    ctrl_sequencer #(
        .ALUCTL_W(ALUCTL_W), .MAC_LAT(MAC_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .opcode_i(opcode),
        .ctrl_valid_o(ctrl_valid), .ctrl_ready_i(ctrl_ready),
        .alu_ctrl1_o(alu_ctrl1), .alu_ctrl2_o(alu_ctrl2),
        .alu_src_o(alu_src), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .mem_req_o(mem_req), .mem_write_o(mem_write),
        .mem_ack_i(mem_ack), .reg_write_o(reg_write),
        .illegal_op_o(illegal_op), .mem_timeout_o(mem_timeout),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit       m_busy = 0;
    bit [3:0] m_op = 0;
    int       m_ready_left = 0;  // ctrl_ready cycles a MAC still needs
    int       m_waited = 0;      // cycles already spent waiting on memory
    int       m_err = 0;
    bit       m_illegal = 0;

    function automatic bit is_legal(input bit [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF};
    endfunction

    function automatic bit is_mem(input bit [3:0] op);
        return op == 4'hE || op == 4'hF;
    endfunction

    // Compare all outputs against the model, then advance it across the next edge.
    always @(negedge clk) begin
        int e_rdy, e_cv, e_a1, e_a2, e_m2r, e_req, e_wr, e_rw, e_ill, e_tmo, e_err;
        bit fin, nxt_ill;
        if (!rst_n) begin
            e_rdy = 1; e_cv = 0; e_a1 = 7; e_a2 = 7; e_m2r = 0; e_req = 0;
            e_wr = 0; e_rw = 0; e_ill = 0; e_tmo = 0; e_err = 0;
        end else begin
            e_rdy = m_busy ? 0 : 1;
            e_cv  = m_busy ? 1 : 0;
            e_a1  = 7;
            if (m_busy) begin
                case (m_op)
                    4'h1: e_a1 = 0;
                    4'h2: e_a1 = 1;
                    4'h3: e_a1 = 2;
                    4'h4: e_a1 = 1;
                    default: e_a1 = 7;
                endcase
            end
            e_a2  = (m_busy && m_op == 4'h4) ? 0 : 7;
            e_m2r = (m_busy && m_op == 4'hE) ? 1 : 0;
            e_req = (m_busy && is_mem(m_op)) ? 1 : 0;
            e_wr  = (m_busy && m_op == 4'hF) ? 1 : 0;
            e_rw  = 0;
            e_tmo = 0;
            if (m_busy) begin
                if (m_op inside {4'h1, 4'h2, 4'h3}) e_rw = ctrl_ready;
                else if (m_op == 4'h4) e_rw = (ctrl_ready && m_ready_left == 1) ? 1 : 0;
                else begin
                    if (mem_ack) e_rw = (m_op == 4'hE) ? 1 : 0;
                    else if (m_waited == MEM_TIMEOUT - 1) e_tmo = 1;
                end
            end
            e_ill = m_illegal;
            e_err = m_err;
        end

        chk("instr_ready", instr_ready, e_rdy);
        chk("ctrl_valid", ctrl_valid, e_cv);
        chk("alu_ctrl1", alu_ctrl1, e_a1);
        chk("alu_ctrl2", alu_ctrl2, e_a2);
        chk("alu_src", alu_src, 0);
        chk("reg_dst", reg_dst, 0);
        chk("mem_to_reg", mem_to_reg, e_m2r);
        chk("mem_req", mem_req, e_req);
        chk("mem_write", mem_write, e_wr);
        chk("reg_write", reg_write, e_rw);
        chk("illegal_op", illegal_op, e_ill);
        chk("mem_timeout", mem_timeout, e_tmo);
        chk("err_count", err_count, e_err);

        if (!rst_n) begin
            m_busy = 0; m_illegal = 0; m_err = 0;
        end else begin
            nxt_ill = 0;
            if (m_busy) begin
                fin = 0;
                if (m_op inside {4'h1, 4'h2, 4'h3}) fin = ctrl_ready;
                else if (m_op == 4'h4) begin
                    if (ctrl_ready) begin
                        m_ready_left--;
                        fin = (m_ready_left == 0);
                    end
                end else begin
                    if (mem_ack || m_waited == MEM_TIMEOUT - 1) fin = 1;
                    else m_waited++;
                end
                if (fin) m_busy = 0;
            end else if (instr_valid) begin
                if (is_legal(opcode)) begin
                    m_busy = 1; m_op = opcode; m_ready_left = MAC_LAT; m_waited = 0;
                end else begin
                    nxt_ill = 1;
                    if (m_err < ERR_MAX) m_err++;
                end
            end
            m_illegal = nxt_ill;
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle's inputs just after the edge; return before the next edge.
    task automatic step(input bit r, input bit v, input bit [3:0] op, input bit rdy, input bit ack);
        @(posedge clk);
        #1;
        rst_n = r; instr_valid = v; opcode = op; ctrl_ready = rdy; mem_ack = ack;
        #2;
    endtask

    int pat[5] = '{1, 0, 0, 0, 1};
    bit [3:0] ops_ill[4] = '{4'h0, 4'h5, 4'hD, 4'h0};
    int exp_err[4] = '{1, 2, 3, 3};
    bit [3:0] legal_ops[6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF};

    initial begin
        int held, rw, rw_last, req, wr, m2r, tmo, tmo_at;
        bit [3:0] op;
        #1 rst_n = 1'b0;
        repeat (3) step(0, 0, 0, 0, 0);
        chk("rst instr_ready", instr_ready, 1);
        chk("rst alu_ctrl1", alu_ctrl1, 7);
        chk("rst alu_ctrl2", alu_ctrl2, 7);
        chk("rst ctrl_valid", ctrl_valid, 0);
        chk("rst err_count", err_count, 0);
        step(1, 0, 0, 0, 0);

        // ADD with the datapath always advancing
        step(1, 1, 4'h1, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("add ctrl_valid", ctrl_valid, 1);
        chk("add alu_ctrl1", alu_ctrl1, 0);
        chk("add alu_ctrl2", alu_ctrl2, 7);
        chk("add reg_write", reg_write, 1);
        chk("add busy", instr_ready, 0);
        step(1, 0, 0, 1, 0);
        chk("add done ready", instr_ready, 1);
        chk("add done valid", ctrl_valid, 0);

        // MAC stalled for three cycles in the middle
        step(1, 1, 4'h4, 1, 0);
        held = 0; rw = 0; rw_last = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, pat[i][0], 0);
            if (ctrl_valid && alu_ctrl1 == 1 && alu_ctrl2 == 0) held++;
            rw += reg_write;
            if (i == 4) rw_last = reg_write;
        end
        chk("mac held cycles", held, 5);
        chk("mac reg_write count", rw, 1);
        chk("mac reg_write at end", rw_last, 1);
        step(1, 0, 0, 1, 0);
        chk("mac done valid", ctrl_valid, 0);

        // LD acked on the fourth wait cycle
        step(1, 1, 4'hE, 0, 0);
        req = 0; wr = 0; m2r = 0; rw = 0; rw_last = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, i == 3);
            req += mem_req; wr += mem_write; m2r += mem_to_reg; rw += reg_write;
            if (i == 3) rw_last = reg_write;
        end
        chk("ld mem_req cycles", req, 4);
        chk("ld mem_write cycles", wr, 0);
        chk("ld mem_to_reg cycles", m2r, 4);
        chk("ld reg_write count", rw, 1);
        chk("ld reg_write at ack", rw_last, 1);
        step(1, 0, 0, 0, 0);
        chk("ld done mem_req", mem_req, 0);

        // ST never acked: times out
        step(1, 1, 4'hF, 0, 0);
        req = 0; wr = 0; rw = 0; tmo = 0; tmo_at = -1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step(1, 0, 0, 1, 0);
            req += mem_req; wr += mem_write; rw += reg_write; tmo += mem_timeout;
            if (mem_timeout) tmo_at = i;
        end
        chk("st mem_req cycles", req, 16);
        chk("st mem_write cycles", wr, 16);
        chk("st reg_write count", rw, 0);
        chk("st timeout count", tmo, 1);
        chk("st timeout cycle", tmo_at, 15);
        step(1, 0, 0, 0, 0);
        chk("st done mem_req", mem_req, 0);
        chk("st done ready", instr_ready, 1);

        // illegal opcodes with a 2-bit saturating counter
        for (int i = 0; i < 4; i++) begin
            step(1, 1, ops_ill[i], 1, 0);
            step(1, 0, 0, 1, 0);
            chk("ill pulse", illegal_op, 1);
            chk("ill ctrl_valid", ctrl_valid, 0);
            chk("ill err_count", err_count, exp_err[i]);
        end
        step(1, 0, 0, 1, 0);
        chk("ill pulse ends", illegal_op, 0);

        // reset in MAC_HOLD
        step(1, 1, 4'h4, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("rst mac ctrl_valid", ctrl_valid, 0);
        chk("rst mac alu_ctrl1", alu_ctrl1, 7);
        chk("rst mac alu_ctrl2", alu_ctrl2, 7);
        chk("rst mac reg_write", reg_write, 0);
        chk("rst mac err_count", err_count, 0);
        rw = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0);
            rw += reg_write;
        end
        chk("rst mac no reg_write", rw, 0);

        // reset in MEM_WAIT, with a stray ack after release
        step(1, 1, 4'hE, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("rst mem mem_req", mem_req, 0);
        chk("rst mem mem_to_reg", mem_to_reg, 0);
        chk("rst mem instr_ready", instr_ready, 1);
        rw = 0; tmo = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1);
            rw += reg_write; tmo += mem_timeout;
        end
        chk("rst mem no reg_write", rw, 0);
        chk("rst mem no timeout", tmo, 0);

        // randomized traffic, checked by the per-cycle model compare
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
            else op = legal_ops[$urandom_range(0, 5)];
            step($urandom_range(0, 249) != 0, $urandom_range(0, 2) != 0, op,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
